// File: rtl/brightness_pwm_gen.sv
// -----------------------------------------------------------------------------
// brightness_pwm_gen
//
// Produces the display-blanking signal for the anode gating stage. When pwm is
// 1, all of the active-low anodes are forced off. The block holds an 8-bit
// brightness level. Single-cycle requests from the debounced button logic step
// this level up or down. A new level reaches the comparator only at a PWM
// period boundary, so no period is ever truncated or glitched.
//
// Parameters
//   PRESC_DIV  clk cycles per PWM phase step (>= 1)
//   STEP       brightness increment/decrement per request (1..255)
//   INIT_DUTY  brightness level after reset (0..255)
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   bright_up    in   one-cycle request to raise brightness
//   bright_down  in   one-cycle request to lower brightness
//   pwm          out  registered blank signal (1 = display off)
//   duty         out  currently requested brightness level
// -----------------------------------------------------------------------------
module brightness_pwm_gen #(
    parameter int PRESC_DIV = 390,
    parameter int STEP      = 32,
    parameter int INIT_DUTY = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bright_up,
    input  logic       bright_down,
    output logic       pwm,
    output logic [7:0] duty
);

    // A divider of 1 would give a zero-width counter, so keep at least one bit.
    localparam int              PW       = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0]   PRE_MAX  = PW'(PRESC_DIV - 1);
    localparam logic [8:0]      STEP9    = 9'(STEP);
    localparam logic [7:0]      INIT8    = 8'(INIT_DUTY);

    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]    phase_q, phase_d;
    logic [7:0]    duty_req_q, duty_req_d;
    logic [7:0]    duty_active_q, duty_active_d;
    logic          pwm_q, pwm_d;

    logic          tick;
    logic          period_wrap;
    logic [8:0]    sum9;
    logic [8:0]    diff9;

    assign tick        = (pre_cnt_q == PRE_MAX);
    assign period_wrap = tick && (phase_q == 8'hFF);

    // Prescaler and phase counter.
    always_comb begin
        pre_cnt_d = pre_cnt_q + PW'(1);
        phase_d   = phase_q;
        if (tick) begin
            pre_cnt_d = '0;
            phase_d   = phase_q + 8'd1;
        end
    end

    // Requested level. Requests are evaluated in 9 bits. For the sum, bit 8 is
    // the carry out (overflow past 255). For the difference, bit 8 is the
    // borrow (result below 0). Both cases saturate.
    assign sum9  = {1'b0, duty_req_q} + STEP9;
    assign diff9 = {1'b0, duty_req_q} - STEP9;

    always_comb begin
        duty_req_d = duty_req_q;
        if (bright_up && !bright_down) begin
            duty_req_d = sum9[8] ? 8'hFF : sum9[7:0];
        end else if (bright_down && !bright_up) begin
            duty_req_d = diff9[8] ? 8'h00 : diff9[7:0];
        end
    end

    // The shadow level is loaded at the period wrap from the registered
    // request. A request that lands on the wrap cycle itself only reaches the
    // comparator at the following wrap.
    always_comb begin
        duty_active_d = duty_active_q;
        if (period_wrap) begin
            duty_active_d = duty_req_q;
        end
    end

    // Blank while the phase is at or above the active level. A level of 0
    // keeps the display dark. A level of 255 still blanks the final phase step.
    always_comb begin
        pwm_d = (phase_q >= duty_active_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q     <= '0;
            phase_q       <= 8'd0;
            duty_req_q    <= INIT8;
            duty_active_q <= INIT8;
            pwm_q         <= 1'b1;
        end else begin
            pre_cnt_q     <= pre_cnt_d;
            phase_q       <= phase_d;
            duty_req_q    <= duty_req_d;
            duty_active_q <= duty_active_d;
            pwm_q         <= pwm_d;
        end
    end

    assign pwm  = pwm_q;
    assign duty = duty_req_q;

endmodule
